alsu_cmd_master: RTL and testbench

ALSU_CMD_MASTER -- requirements
Module: alsu_cmd_master

---
 rtl/alsu_cmd_master.sv | 146 ++++++++++++++
 tb/tb_alsu_cmd_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_cmd_master.sv
`default_nettype none
// ============================================================================
// alsu_cmd_master : queues ALSU commands, drives one at a time, returns results
// Revision: 1.0
// ============================================================================
module alsu_cmd_master #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_data,
  output logic              alsu_rst,
  output logic [2:0]        opcode,
  output logic signed [2:0] A,
  output logic signed [2:0] B,
  output logic              cin,
  output logic              serial_in,
  output logic              red_op_A,
  output logic              red_op_B,
  output logic              bypass_A,
  output logic              bypass_B,
  output logic              direction,
  input  logic signed [5:0] out,
  input  logic [15:0]       leds,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic signed [5:0] rsp_out,
  output logic [15:0]       rsp_leds,
  output logic              rsp_invalid,
  output logic [7:0]        rsp_count
);

  localparam int       c_AW   = $clog2(DEPTH);
  localparam int       c_CW   = $clog2(DEPTH + 1);
  localparam logic [3:0] c_LAST = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_DRIVE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_init_cnt;
  logic [3:0]        r_wait_cnt;
  logic [15:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_CW-1:0]   r_count;
  logic              w_push;
  logic              w_pop;
  logic [15:0]       w_head;

  // Gated by rst so the queue looks closed while reset is held.
  assign cmd_ready = rst & (r_count < c_CW'(DEPTH));
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_init_cnt  <= 1'b0;
      r_wait_cnt  <= '0;
      alsu_rst    <= 1'b1;
      {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
       bypass_A, bypass_B, direction} <= 16'h0000;
      rsp_valid   <= 1'b0;
      rsp_out     <= '0;
      rsp_leds    <= '0;
      rsp_invalid <= 1'b0;
      rsp_count   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_init_cnt) begin
            alsu_rst <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_init_cnt <= 1'b1;
          end
        end
        S_IDLE: begin
          if (r_count != '0) begin
            {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
             bypass_A, bypass_B, direction} <= w_head;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // ALSU inputs stay frozen until the result has been captured.
          if (r_wait_cnt == c_LAST) begin
            rsp_out     <= out;
            rsp_leds    <= leds;
            rsp_invalid <= |leds;
            rsp_valid   <= 1'b1;
            {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
             bypass_A, bypass_B, direction} <= 16'h0000;
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_count <= rsp_count + 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_alsu_cmd_master : directed + random checks of the ALSU command master
// Revision: 1.0
// ============================================================================
module tb_alsu_cmd_master;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = 16'h0000;
  logic        alsu_rst;
  logic [2:0]  opcode, A, B;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [5:0]  out;
  logic [15:0] leds;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  rsp_out;
  logic [15:0] rsp_leds;
  logic        rsp_invalid;
  logic [7:0]  rsp_count;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] q[$];
  int          exp_count = 0;
  bit          cmd_fire, rsp_fire;
  logic [21:0] pipe [LATENCY];
  logic [15:0] w_drv;

  always #5 clk = ~clk;

  alsu_cmd_master #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .alsu_rst(alsu_rst), .opcode(opcode), .A(A), .B(B),
    .cin(cin), .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
    .out(out), .leds(leds), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid),
    .rsp_count(rsp_count)
  );

  // ALSU stand-in: {leds, out} as a function of the packed command fields.
  function automatic logic [21:0] stub_fn(input logic [15:0] c);
    logic [2:0]  op;
    logic [5:0]  o;
    logic [15:0] l;
    op = c[15:13];
    o  = (c[12:7] ^ c[6:1]) + (c[0] ? {op, op} : 6'd0);
    l  = (op == 3'b110) ? 16'hFFFF : (op[0] ? {op, c[12:0]} : 16'h0000);
    return {l, o};
  endfunction

  assign w_drv = {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
                  bypass_A, bypass_B, direction};

  always @(posedge clk) begin
    pipe[0] <= stub_fn(w_drv);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign out  = pipe[LATENCY-1][5:0];
  assign leds = pipe[LATENCY-1][21:6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // One clock step from a negedge to the next; model tracks accepted commands.
  task automatic cycle();
    logic [21:0] e;
    cmd_fire = cmd_valid && cmd_ready;
    rsp_fire = rsp_valid && rsp_ready;
    @(posedge clk);
    if (cmd_fire) q.push_back(cmd_data);
    if (rsp_fire && q.size() > 0) begin
      void'(q.pop_front());
      exp_count++;
    end
    @(negedge clk);
    check("rsp_count", {24'h0, rsp_count}, {24'h0, 8'(exp_count)});
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
      end else begin
        e = stub_fn(q[0]);
        check("rsp_out", {26'h0, rsp_out}, {26'h0, e[5:0]});
        check("rsp_leds", {16'h0, rsp_leds}, {16'h0, e[21:6]});
        check("rsp_invalid", {31'h0, rsp_invalid}, {31'h0, (e[21:6] != 16'h0)});
      end
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      cycle();
      n++;
    end
    check(tag, {31'h0, rsp_valid}, 32'h1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_alsu_rst"}, {31'h0, alsu_rst}, 32'h1);
    check({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h0);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_out"}, {26'h0, rsp_out}, 32'h0);
    check({tag, "_rsp_leds"}, {16'h0, rsp_leds}, 32'h0);
    check({tag, "_rsp_invalid"}, {31'h0, rsp_invalid}, 32'h0);
    check({tag, "_rsp_count"}, {24'h0, rsp_count}, 32'h0);
    check({tag, "_alsu_fields"}, {16'h0, w_drv}, 32'h0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, "_ready_now"}, {31'h0, cmd_ready}, 32'h1);
    check({tag, "_alsu_rst0"}, {31'h0, alsu_rst}, 32'h1);
    @(negedge clk);
    check({tag, "_alsu_rst1"}, {31'h0, alsu_rst}, 32'h1);
    @(negedge clk);
    check({tag, "_alsu_rst_off"}, {31'h0, alsu_rst}, 32'h0);
    check({tag, "_no_rsp"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_ready"}, {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    int n;
    int sent;
    bit pend;

    // Reset held, then released
    repeat (3) @(negedge clk);
    check_reset_values("por");
    release_reset("init");

    // Single known command
    cmd_valid = 1'b1;
    cmd_data  = 16'h4A80;
    check("c1_ready", {31'h0, cmd_ready}, 32'h1);
    cycle();
    cmd_valid = 1'b0;
    check("c1_idle_fields", {16'h0, w_drv}, 32'h0);
    cycle();
    check("c1_drive_opcode", {29'h0, opcode}, 32'd2);
    check("c1_drive_A", {29'h0, A}, 32'd2);
    check("c1_drive_B", {29'h0, B}, 32'b101);
    for (int k = 1; k <= LATENCY; k++) begin
      cycle();
      check("c1_wait_no_rsp", {31'h0, rsp_valid}, 32'h0);
      check("c1_wait_hold", {16'h0, w_drv}, 32'h4A80);
    end
    cycle();
    check("c1_rsp_rise", {31'h0, rsp_valid}, 32'h1);
    check("c1_rsp_out", {26'h0, rsp_out}, 32'h15);
    check("c1_rsp_invalid", {31'h0, rsp_invalid}, 32'h0);
    check("c1_resp_fields", {16'h0, w_drv}, 32'h0);
    cycle();
    check("c1_rsp_stable", {26'h0, rsp_out}, 32'h15);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    check("c1_rsp_done", {31'h0, rsp_valid}, 32'h0);
    check("c1_count", {24'h0, rsp_count}, 32'd1);

    // Opcode 110 lights every led
    cmd_valid = 1'b1;
    cmd_data  = {3'b110, 13'($urandom)};
    cycle();
    cmd_valid = 1'b0;
    wait_rsp("c2_wait");
    check("c2_invalid", {31'h0, rsp_invalid}, 32'h1);
    check("c2_leds", {16'h0, rsp_leds}, 32'hFFFF);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;

    // Queue fills behind a stalled response
    cmd_valid = 1'b1;
    cmd_data  = 16'($urandom);
    cycle();
    cmd_valid = 1'b0;
    wait_rsp("c3_first_rsp");
    for (int i = 0; i < DEPTH; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 16'($urandom);
      check("c3_slot_ready", {31'h0, cmd_ready}, 32'h1);
      cycle();
    end
    cmd_data = 16'($urandom);
    check("c3_full", {31'h0, cmd_ready}, 32'h0);
    repeat (3) begin
      cycle();
      check("c3_stall", {31'h0, cmd_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!cmd_fire && n < 20);
    check("c3_last_accepted", {31'h0, cmd_fire}, 32'h1);
    cmd_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    check("c3_drained", q.size(), 32'h0);
    check("c3_count", {24'h0, rsp_count}, 32'd8);
    rsp_ready = 1'b0;

    // Reset while a command is in flight and three are queued
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 16'($urandom);
      cycle();
    end
    cmd_valid = 1'b0;
    check("c4_busy", {31'h0, rsp_valid}, 32'h0);
    #2 rst = 1'b0;
    #1;
    check_reset_values("midrst");
    q.delete();
    exp_count = 0;
    @(negedge clk);
    release_reset("reinit");
    rsp_ready = 1'b1;
    repeat (20) begin
      cycle();
      check("c4_no_drive", {16'h0, w_drv}, 32'h0);
      check("c4_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end

    // Random traffic through 256 completions
    sent = 0;
    pend = 1'b0;
    n    = 0;
    while (exp_count < 256 && n < 20000) begin
      if (!pend && sent < 256 && ($urandom % 3) != 0) begin
        pend     = 1'b1;
        cmd_data = 16'($urandom);
      end
      cmd_valid = pend;
      rsp_ready = ($urandom % 4) != 0;
      cycle();
      if (cmd_fire) begin
        pend = 1'b0;
        sent++;
      end
      n++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("c5_total", exp_count, 32'd256);
    check("c5_wrap", {24'h0, rsp_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
